seq_trigger_detector: RTL and testbench

Parametrised, clocked successor to the combinational-latch AES sequence trigger. It watches a sampled data word, such as the AES state or plaintext. It raises a trigger once NUM_STAGES programmed patterns have been seen in order. Each consecutive match must arrive within a cycle window. It adds per-bit masking, timeout, restart-on-first-pattern, sticky or pulse mode, and a saturating fire counter. It sits beside the AES core and taps the same state bus.

---
 rtl/seq_trigger_detector.sv | 107 ++++++++++
 tb/tb_seq_trigger_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_trigger_detector.sv
// Sequence trigger: fires after NUM_STAGES masked patterns are seen in order,
// each within WINDOW cycles of the previous match.
module seq_trigger_detector #(
  parameter int DATA_W     = 128,
  parameter int NUM_STAGES = 4,
  parameter int WINDOW     = 16,
  parameter int STICKY     = 1,
  parameter int CNT_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             clear,
  input  logic                             data_valid,
  input  logic [DATA_W-1:0]                data,
  input  logic [NUM_STAGES*DATA_W-1:0]     pattern_flat,
  input  logic [DATA_W-1:0]                mask,
  output logic [$clog2(NUM_STAGES+1)-1:0]  stage,
  output logic                             trig,
  output logic [CNT_W-1:0]                 fire_cnt
);

  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam int TW = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;

  logic [SW-1:0]         stage_reg, stage_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  trig_reg;
  logic [CNT_W-1:0]      fire_cnt_reg, fire_cnt_next;
  logic [NUM_STAGES-1:0] hit_vec;
  logic                  hit_cur;
  logic                  complete;

  // One masked comparator per stage; the current stage's result is selected below.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
      assign hit_vec[gi] = ~|((data ^ pattern_flat[gi*DATA_W +: DATA_W]) & mask);
    end
  endgenerate

  always_comb begin
    hit_cur = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (int'(stage_reg) == k) hit_cur = hit_vec[k];
    end
  end

  always_comb begin
    stage_next = stage_reg;
    timer_next = timer_reg;
    complete   = 1'b0;
    if (data_valid) begin
      timer_next = '0;
      if (hit_cur) begin
        if (int'(stage_reg) == NUM_STAGES - 1) begin
          complete   = 1'b1;
          stage_next = '0;
        end else begin
          stage_next = stage_reg + 1'b1;
        end
      end else if (hit_vec[0] && (stage_reg != '0)) begin
        stage_next = SW'(1);
      end else begin
        stage_next = '0;
      end
    end else if ((WINDOW > 0) && (stage_reg != '0)) begin
      // Idle cycle inside an attempt: abandon it once the gap reaches WINDOW.
      if (int'(timer_reg) + 1 >= WINDOW) begin
        stage_next = '0;
        timer_next = '0;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
  end

  assign fire_cnt_next = (&fire_cnt_reg) ? fire_cnt_reg : fire_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg    <= '0;
      timer_reg    <= '0;
      trig_reg     <= 1'b0;
      fire_cnt_reg <= '0;
    end else if (clear) begin
      stage_reg <= '0;
      timer_reg <= '0;
      trig_reg  <= 1'b0;
    end else if (!enable) begin
      if (STICKY == 0) trig_reg <= 1'b0;
    end else begin
      stage_reg <= stage_next;
      timer_reg <= timer_next;
      if (complete) begin
        trig_reg     <= 1'b1;
        fire_cnt_reg <= fire_cnt_next;
      end else if (STICKY == 0) begin
        trig_reg <= 1'b0;
      end
    end
  end

  assign stage    = stage_reg;
  assign trig     = trig_reg;
  assign fire_cnt = fire_cnt_reg;

endmodule

// File: tb/tb_seq_trigger_detector.sv
// Bench: sticky/8-bit-counter and pulse/2-bit-counter detectors share stimulus
// and are compared every cycle against a sequence-level reference model.
module tb_seq_trigger_detector;

  logic         clk = 1'b0;
  logic         rst_n, enable, clear, data_valid;
  logic [127:0] data, mask;
  logic [511:0] pattern_flat;
  logic [127:0] pat [4];

  logic [2:0]   u0_stage, u1_stage;
  logic         u0_trig, u1_trig;
  logic [7:0]   u0_fire;
  logic [1:0]   u1_fire;

  int vectors = 0;
  int errors  = 0;

  int m_stage [2];
  int m_timer [2];
  int m_fire  [2];
  bit m_trig  [2];

  always #5 clk = ~clk;

  seq_trigger_detector #(.DATA_W(128), .NUM_STAGES(4), .WINDOW(16), .STICKY(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .data_valid(data_valid),
    .data(data), .pattern_flat(pattern_flat), .mask(mask),
    .stage(u0_stage), .trig(u0_trig), .fire_cnt(u0_fire));

  seq_trigger_detector #(.DATA_W(128), .NUM_STAGES(4), .WINDOW(16), .STICKY(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .data_valid(data_valid),
    .data(data), .pattern_flat(pattern_flat), .mask(mask),
    .stage(u1_stage), .trig(u1_trig), .fire_cnt(u1_fire));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int k);
    return ((data ^ pat[k]) & mask) == 128'd0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_stage[i] = 0; m_timer[i] = 0; m_fire[i] = 0; m_trig[i] = 1'b0;
    end
  endfunction

  // Sequence-level behaviour: how many patterns matched, idle gap length, fires.
  function automatic void model_step(input int i);
    bit sticky = (i == 0);
    int cmax   = (i == 0) ? 255 : 3;
    bit done   = 1'b0;
    if (clear) begin
      m_stage[i] = 0; m_timer[i] = 0; m_trig[i] = 1'b0;
      return;
    end
    if (!sticky) m_trig[i] = 1'b0;
    if (!enable) return;
    if (data_valid) begin
      m_timer[i] = 0;
      if (m_hit(m_stage[i])) begin
        m_stage[i]++;
        if (m_stage[i] == 4) begin done = 1'b1; m_stage[i] = 0; end
      end else if (m_stage[i] > 0 && m_hit(0)) begin
        m_stage[i] = 1;
      end else begin
        m_stage[i] = 0;
      end
    end else if (m_stage[i] > 0) begin
      m_timer[i]++;
      if (m_timer[i] == 16) begin m_stage[i] = 0; m_timer[i] = 0; end
    end
    if (done) begin
      m_trig[i] = 1'b1;
      if (m_fire[i] < cmax) m_fire[i]++;
    end
  endfunction

  task automatic compare_all();
    check("u0_stage", 32'(u0_stage), 32'(m_stage[0]));
    check("u0_trig",  32'(u0_trig),  32'(m_trig[0]));
    check("u0_fire",  32'(u0_fire),  32'(m_fire[0]));
    check("u1_stage", 32'(u1_stage), 32'(m_stage[1]));
    check("u1_trig",  32'(u1_trig),  32'(m_trig[1]));
    check("u1_fire",  32'(u1_fire),  32'(m_fire[1]));
  endtask

  task automatic tick(input logic v, input logic [127:0] d);
    data_valid = v;
    data       = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 128'd0);
  endtask

  task automatic feed(input int k);
    tick(1'b1, pat[k]);
  endtask

  task automatic full_seq();
    for (int k = 0; k < 4; k++) feed(k);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1'b0, 128'd0);
    clear = 1'b0;
  endtask

  logic [127:0] tmp;
  logic [31:0]  junk;
  int           fire_before;

  initial begin
    pat[0] = 128'h3243f6a8885a308d313198a2e0370734;
    pat[1] = 128'h00112233445566778899aabbccddeeff;
    pat[2] = 128'h0;
    pat[3] = 128'h1;
    pattern_flat = {pat[3], pat[2], pat[1], pat[0]};
    mask = '1;
    enable = 1'b1; clear = 1'b0; data_valid = 1'b0; data = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    idle(3);
    #2 rst_n = 1'b1;
    check("reset_stage", 32'(u0_stage), 32'd0);
    check("reset_fire",  32'(u0_fire),  32'd0);

    $display("basic sequence");
    feed(0); check("basic_s1", 32'(u0_stage), 32'd1);
    feed(1); check("basic_s2", 32'(u0_stage), 32'd2);
    feed(2); check("basic_s3", 32'(u0_stage), 32'd3);
    feed(3); check("basic_trig", 32'(u0_trig), 32'd1);
    check("basic_fire", 32'(u0_fire), 32'd1);
    check("basic_pulse", 32'(u1_trig), 32'd1);
    idle(100);
    check("basic_hold", 32'(u0_trig), 32'd1);
    check("basic_pulse_low", 32'(u1_trig), 32'd0);

    $display("timeout");
    do_clear();
    feed(0); feed(1);
    idle(15);
    check("to_before", 32'(u0_stage), 32'd2);
    idle(1);
    check("to_expired", 32'(u0_stage), 32'd0);
    feed(2);
    check("to_p2_stage", 32'(u0_stage), 32'd0);
    check("to_p2_trig",  32'(u0_trig),  32'd0);
    feed(0); feed(1); idle(15); feed(2); feed(3);
    check("gap15_trig", 32'(u0_trig), 32'd1);

    $display("restart and mismatch");
    feed(0); feed(1); feed(0);
    check("restart_s1", 32'(u0_stage), 32'd1);
    feed(1); feed(2); feed(3);
    check("restart_fire", 32'(u0_fire), 32'd3);
    feed(0); feed(1); tick(1'b1, 128'hdeadbeef);
    check("mismatch_stage", 32'(u0_stage), 32'd0);

    $display("mask and pulse");
    mask = {{96{1'b1}}, 32'h0};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        junk = $urandom | 32'h1;
        tmp  = pat[k] ^ {96'd0, junk};
        tick(1'b1, tmp);
      end
      check("mask_pulse_hi", 32'(u1_trig), 32'd1);
      idle(1);
      check("mask_pulse_lo", 32'(u1_trig), 32'd0);
    end
    mask = '1;
    check("sat_u0_fire", 32'(u0_fire), 32'd5);
    check("sat_u1_fire", 32'(u1_fire), 32'd3);

    $display("enable hold");
    feed(0); feed(1);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 1)), pat[$urandom_range(0, 3)]);
    check("en_hold", 32'(u0_stage), 32'd2);
    enable = 1'b1;
    feed(2); feed(3);
    check("en_done", 32'(u0_fire), 32'd6);

    $display("clear");
    fire_before = int'(u0_fire);
    feed(0);
    do_clear();
    check("clr_stage", 32'(u0_stage), 32'd0);
    check("clr_trig",  32'(u0_trig),  32'd0);
    check("clr_fire",  32'(u0_fire),  32'd6);

    $display("async reset");
    feed(0); feed(1); feed(2);
    check("ar_pre", 32'(u0_stage), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_stage", 32'(u0_stage), 32'd0);
    check("ar_trig",  32'(u0_trig),  32'd0);
    check("ar_fire",  32'(u0_fire),  32'd0);
    compare_all();
    idle(2);
    rst_n = 1'b1;
    full_seq();
    check("ar_after", 32'(u0_trig), 32'd1);

    $display("random phase");
    for (int it = 0; it < 3000; it++) begin
      if (it % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: mask = '1;
          1: mask = {{96{1'b1}}, 32'h0};
          default: mask = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
        endcase
      end
      enable = ($urandom_range(0, 15) != 0);
      clear  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) begin
        clear = 1'b0;
        idle($urandom_range(14, 18));
      end else if ($urandom_range(0, 3) == 0) begin
        tick(1'b0, {$urandom, $urandom, $urandom, $urandom});
      end else begin
        case ($urandom_range(0, 3))
          0: tmp = {$urandom, $urandom, $urandom, $urandom};
          1: tmp = pat[$urandom_range(0, 3)];
          default: tmp = pat[m_stage[0]];
        endcase
        tick(1'b1, tmp);
      end
      clear = 1'b0;
    end
    if (fire_before < 0) check("fire_before", 32'(fire_before), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
